wb_copy_master: RTL and testbench
=================================

// Module: wb_copy_master
// PURPOSE
//   Wishbone classic single-transfer initiator that copies a block of 32-bit words from a source region
//   (e.g. the boot ROM) to a destination region (e.g. SRAM) after a start pulse.
//   Sits on the SoC Wishbone bus as a master beside the CPU; used at boot to shadow ROM code into RAM.
//   Reports busy/done/error and handles slave ack, err and rty terminations.
// PARAMETERS
//   AW         32    address width
//   DW         32    data width (fixed at 32; address stride = DW/8 = 4)
//   LW         16    width of the word-count input
//   TIMEOUT    255   cycles without ack/err/rty before abort; must be >=1
//   MAX_RETRY  7     rty terminations accepted per transfer before abort
// PORTS
//   clk          in   1      system clock
//   rst          in   1      asynchronous, active-low reset (0 = reset)
//   start        in   1      one-cycle request; sampled only in IDLE
//   src_adr      in   AW     byte address of first source word (bits [1:0] ignored)
//   dst_adr      in   AW     byte address of first destination word (bits [1:0] ignored)
//   len          in   LW     number of words to copy
//   busy         out  1      copy in progress
//   done         out  1      one-cycle pulse at completion (success or error)
//   error        out  1      sticky; set on err/timeout/retry overflow; cleared by next accepted start
//   words_done   out  LW     words written successfully in current/last copy
//   wb_adr_o     out  AW     bus address
//   wb_dat_o     out  DW     write data
//   wb_sel_o     out  4      byte select, always 4'hf when stb
//   wb_we_o      out  1      1 = write
//   wb_cyc_o     out  1      bus cycle
//   wb_stb_o     out  1      strobe
//   wb_dat_i     in   DW     read data
//   wb_ack_i     in   1      normal termination
//   wb_err_i     in   1      error termination
//   wb_rty_i     in   1      retry termination
// BEHAVIOUR
//   Reset (async, rst=0): state IDLE; all outputs 0 incl. wb_cyc_o/wb_stb_o (dropped immediately).
//   All outputs registered. cyc == stb at all times. Termination priority: err > rty > ack.
//   States: IDLE, RD, WR, GAP, FIN.
//   IDLE: start=1 & len!=0 -> latch src/dst/len, words_done=0, error=0, busy=1, -> RD.
//         start=1 & len==0 -> error=0, -> FIN (no bus activity). start while not IDLE is ignored.
//   RD:  cyc=stb=1, we=0, adr=src. ack -> capture wb_dat_i, -> GAP then WR.
//   WR:  cyc=stb=1, we=1, adr=dst, dat=captured word. ack -> words_done++, src+=4, dst+=4;
//        words_done==len -> FIN else GAP then RD.
//   GAP: exactly one cycle cyc=stb=0 after every termination (required by registered-ack slaves
//        that toggle ack while stb held).
//   rty: drop stb one cycle, reissue identical transfer; retry counter++ ; counter>MAX_RETRY -> abort.
//        Retry counter clears on every ack.
//   err or TIMEOUT cycles of stb without termination -> abort: cyc/stb drop next cycle, error=1, -> FIN.
//   Timeout counter clears at each stb assertion.
//   FIN: done=1 for one cycle, busy=0, -> IDLE. words_done holds its value.
//   Zero-wait slave: 4 cycles per word (RD, GAP, WR, GAP); first stb one cycle after start.
//   Address arithmetic modulo 2^AW (wraps silently); word count modulo 2^LW, len max 2^LW-1.
//   Termination inputs while stb=0 are ignored.
// TESTING
//   1. Zero-wait slave, src=0x0, dst=0x1000, len=3, ROM {A,B,C} -> writes A@0x1000,B@0x1004,C@0x1008;
//      done at cycle 13 after start; words_done=3, error=0.
//   2. start with len=0 -> done pulse next cycle, no cyc, error=0, words_done=0.
//   3. err on 2nd write of len=4 -> cyc drops, error=1, done pulse, words_done=1; next start clears error.
//   4. rty twice on first read then ack -> same address reissued 3 times, copy completes error=0;
//      MAX_RETRY+1 rty -> error=1.
//   5. Slave never responds, TIMEOUT=8 -> stb high 8 cycles then abort, error=1, done pulse.
//   6. rst low mid-WR -> cyc/stb/busy 0 same cycle; after release, start copies from scratch correctly.

Source files
------------

// File: rtl/wb_copy_master.sv
// Wishbone classic initiator that copies a block of 32-bit words from src to dst, one
// single transfer at a time, with retry/error/timeout handling and registered outputs.
module wb_copy_master #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int LW        = 16,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src_adr,
  input  logic [AW-1:0] dst_adr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [LW-1:0] words_done,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {IDLE, RD, WR, GAP, FIN} state_t;

  state_t        state, nxt, ret_q, ret_nxt;
  logic [AW-1:0] src_q, dst_q;
  logic [LW-1:0] len_q;
  logic [DW-1:0] rdata_q;
  logic [TW-1:0] tmo_cnt;
  logic [RW-1:0] rty_cnt;
  logic          on_bus, t_ack, t_rty, t_err, tmo_hit, rty_ovf, last_wr, start_ok, abort;
  logic          stb_d, we_d, busy_d, done_d;
  logic [AW-1:0] adr_d;
  logic [DW-1:0] dat_d;

  // stb is high exactly in RD/WR, so terminations outside those states are ignored
  assign on_bus   = (state == RD) || (state == WR);
  assign t_err    = on_bus && wb_err_i;
  assign t_rty    = on_bus && wb_rty_i && !wb_err_i;
  assign t_ack    = on_bus && wb_ack_i && !wb_err_i && !wb_rty_i;
  assign tmo_hit  = on_bus && !wb_ack_i && !wb_err_i && !wb_rty_i && (tmo_cnt == TW'(TIMEOUT - 1));
  assign rty_ovf  = t_rty && (rty_cnt == RW'(MAX_RETRY));
  assign last_wr  = (state == WR) && ((words_done + LW'(1)) == len_q);
  assign start_ok = (state == IDLE) && start;
  assign abort    = t_err || rty_ovf || tmo_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // ret_nxt remembers where GAP goes: reissue on rty, advance on ack
  always_comb begin
    nxt     = state;
    ret_nxt = ret_q;
    case (state)
      IDLE: if (start) nxt = (len != '0) ? RD : FIN;
      RD, WR: begin
        if (abort) nxt = FIN;
        else if (t_rty) begin
          nxt     = GAP;
          ret_nxt = state;
        end else if (t_ack) begin
          nxt     = GAP;
          ret_nxt = (state == RD) ? WR : (last_wr ? FIN : RD);
        end
      end
      GAP:     nxt = ret_q;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered below
  always_comb begin
    stb_d  = (nxt == RD) || (nxt == WR);
    we_d   = (nxt == WR);
    busy_d = stb_d || (nxt == GAP);
    done_d = (nxt == FIN);
    adr_d  = '0;
    if (stb_d) adr_d = (state == IDLE) ? {src_adr[AW-1:2], 2'b00} : (we_d ? dst_q : src_q);
    dat_d  = we_d ? rdata_q : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
    end else begin
      busy     <= busy_d;
      done     <= done_d;
      wb_cyc_o <= stb_d;
      wb_stb_o <= stb_d;
      wb_we_o  <= we_d;
      wb_sel_o <= {4{stb_d}};
      wb_adr_o <= adr_d;
      wb_dat_o <= dat_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ret_q      <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      rdata_q    <= '0;
      tmo_cnt    <= '0;
      rty_cnt    <= '0;
      words_done <= '0;
      error      <= 1'b0;
    end else begin
      ret_q   <= ret_nxt;
      tmo_cnt <= on_bus ? tmo_cnt + TW'(1) : '0;
      if (start_ok) begin
        src_q      <= {src_adr[AW-1:2], 2'b00};
        dst_q      <= {dst_adr[AW-1:2], 2'b00};
        len_q      <= len;
        words_done <= '0;
        error      <= 1'b0;
        rty_cnt    <= '0;
      end
      if (abort) error <= 1'b1;
      if (t_rty) rty_cnt <= rty_cnt + RW'(1);
      if (t_ack) begin
        rty_cnt <= '0;
        if (state == RD) rdata_q <= wb_dat_i;
        else begin
          words_done <= words_done + LW'(1);
          src_q      <= src_q + AW'(4);
          dst_q      <= dst_q + AW'(4);
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_copy_master.sv
// Bench for wb_copy_master: zero-wait ROM-like slave with err/rty/silence/wait injection
// and a write scoreboard fed when each copy is started.
module tb_wb_copy_master;
  localparam int AW = 32, DW = 32, LW = 16, TMO = 8, MR = 3;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [AW-1:0] src_adr = '0, dst_adr = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, error;
  logic [LW-1:0] words_done;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, wb_rty_i;

  typedef struct packed {logic [AW-1:0] adr; logic [DW-1:0] dat;} wr_t;
  wr_t exp_q[$];
  int  n_cmp = 0, n_bad = 0;

  // slave knobs (written by the stimulus) and slave state (written by the slave)
  bit            silent = 1'b0;
  int            err_wr_idx = -1, rty_budget = 0, wr_wait = 0;
  logic [AW-1:0] rd_watch = '1;
  int            wr_cnt = 0, rty_used = 0, stb_age = 0, rd_issue = 0, proto_bad = 0;

  always #5 clk = ~clk;

  wb_copy_master #(.AW(AW), .DW(DW), .LW(LW), .TIMEOUT(TMO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .start(start), .src_adr(src_adr), .dst_adr(dst_adr), .len(len),
    .busy(busy), .done(done), .error(error), .words_done(words_done),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i));

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {a[17:2] ^ 16'h5a5a, ~a[17:2]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  always_comb begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    wb_dat_i = wb_we_o ? '0 : rom_word(wb_adr_o);
    if (wb_stb_o && !silent) begin
      if (wb_we_o && wr_cnt == err_wr_idx)          wb_err_i = 1'b1;
      else if (!wb_we_o && rty_used < rty_budget)   wb_rty_i = 1'b1;
      else if (!wb_we_o || stb_age >= wr_wait)      wb_ack_i = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!wb_stb_o || wb_ack_i || wb_err_i || wb_rty_i) stb_age <= 0;
    else stb_age <= stb_age + 1;
    if (wb_stb_o && wb_we_o && wb_ack_i) wr_cnt <= wr_cnt + 1;
    if (wb_stb_o && wb_rty_i) rty_used <= rty_used + 1;
  end

  always @(negedge clk) begin
    wr_t e;
    if (wb_cyc_o !== wb_stb_o || (wb_stb_o && wb_sel_o !== 4'hf)) proto_bad++;
    if (wb_stb_o && !wb_we_o && wb_adr_o == rd_watch) rd_issue++;
    if (wb_stb_o && wb_we_o && wb_ack_i) begin
      if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("wr_adr", wb_adr_o, e.adr);
        chk("wr_dat", wb_dat_o, e.dat);
      end
    end
  end

  // Push the n_ok writes expected to complete, pulse start, wait for done.
  task automatic run(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n,
                     input int n_ok, output int lat, output int first_stb, output int stb_cyc);
    for (int i = 0; i < n_ok; i++) begin
      wr_t e;
      e.adr = {d[AW-1:2], 2'b00} + AW'(4 * i);
      e.dat = rom_word({s[AW-1:2], 2'b00} + AW'(4 * i));
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b1; src_adr = s; dst_adr = d; len = n;
    @(negedge clk);
    start = 1'b0;
    lat = 1; first_stb = 0; stb_cyc = 0;
    while (!done && lat < 200) begin
      if (wb_stb_o) begin
        stb_cyc++;
        if (first_stb == 0) first_stb = lat;
      end
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int lat, fs, sc, base;
    bit found;
    repeat (3) @(negedge clk);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_wd", words_done, 0);
    rst = 1'b1;
    @(negedge clk);

    // basic 3-word copy
    run(32'h0, 32'h1000, 3, 3, lat, fs, sc);
    chk("t1_lat", lat, 13);
    chk("t1_first_stb", fs, 1);
    chk("t1_wd", words_done, 3);
    chk("t1_err", error, 0);
    chk("t1_busy", busy, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_q", exp_q.size(), 0);

    // zero length
    run(32'h40, 32'h2000, 0, 0, lat, fs, sc);
    chk("t2_lat", lat, 1);
    chk("t2_cyc", wb_cyc_o, 0);
    chk("t2_err", error, 0);
    chk("t2_wd", words_done, 0);

    // err on second write
    err_wr_idx = wr_cnt + 1;
    run(32'h100, 32'h3000, 4, 1, lat, fs, sc);
    chk("t3_lat", lat, 8);
    chk("t3_err", error, 1);
    chk("t3_wd", words_done, 1);
    chk("t3_cyc", wb_cyc_o, 0);
    err_wr_idx = -1;

    // two retries then ack; start also clears the sticky error
    rd_watch = 32'h200; base = rd_issue; rty_budget = rty_used + 2;
    run(32'h200, 32'h3100, 2, 2, lat, fs, sc);
    chk("t4_lat", lat, 13);
    chk("t4_issues", rd_issue - base, 3);
    chk("t4_err", error, 0);
    chk("t4_wd", words_done, 2);

    // MAX_RETRY+1 retries abort
    rd_watch = 32'h240; base = rd_issue; rty_budget = rty_used + MR + 1;
    run(32'h240, 32'h3200, 1, 0, lat, fs, sc);
    chk("t4b_lat", lat, 8);
    chk("t4b_issues", rd_issue - base, MR + 1);
    chk("t4b_err", error, 1);
    chk("t4b_wd", words_done, 0);

    // exactly MAX_RETRY retries still succeed; dst low bits ignored
    rd_watch = 32'h280; base = rd_issue; rty_budget = rty_used + MR;
    run(32'h280, 32'h4003, 1, 1, lat, fs, sc);
    chk("t4c_lat", lat, 11);
    chk("t4c_issues", rd_issue - base, MR + 1);
    chk("t4c_err", error, 0);

    // silent slave -> timeout
    silent = 1'b1;
    run(32'h300, 32'h5000, 1, 0, lat, fs, sc);
    chk("t5_lat", lat, TMO + 1);
    chk("t5_stb_cycles", sc, TMO);
    chk("t5_err", error, 1);
    chk("t5_wd", words_done, 0);
    silent = 1'b0;
    chk("t5_q", exp_q.size(), 0);

    // async reset while a write is on the bus, then a fresh copy across the address wrap
    wr_wait = 3;
    @(negedge clk);
    start = 1'b1; src_adr = 32'h400; dst_adr = 32'h6000; len = 3;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (wb_stb_o && wb_we_o) found = 1'b1;
      else @(negedge clk);
    end
    chk("t6_wr_seen", found, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_cyc", wb_cyc_o, 0);
    chk("t6_stb", wb_stb_o, 0);
    chk("t6_busy", busy, 0);
    chk("t6_wd", words_done, 0);
    @(negedge clk);
    rst = 1'b1; wr_wait = 0;
    run(32'hFFFF_FFFC, 32'h7000, 2, 2, lat, fs, sc);
    chk("t6_lat", lat, 9);
    chk("t6_wd2", words_done, 2);
    chk("t6_err", error, 0);

    @(negedge clk);
    chk("final_q", exp_q.size(), 0);
    chk("protocol", proto_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
